// File: rtl/fetch_stage.sv
// Purpose : RV32I instruction-fetch stage; owns PCF and the IF/ID pipeline register.
// Latency : 1 cycle fetch-to-decode (word at PCF in cycle n is in instrD in cycle n+1).
// Backpr. : stall holds PCF and IF/ID; redirect overrides stall; flush bubbles IF/ID only.
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   stall, flush         hazard-unit hold / bubble requests
//   redirect, redirect_pc execute-stage taken branch/jump and its target (bit 0 forced 0)
//   imem_addr            instruction memory address (= PCF, registered)
//   imem_rdata           combinational instruction read data for imem_addr
//   instrD, PCD,         decode-stage instruction, its PC, and PC+4 link value
//   PCPlus4D, validD     validD=0 marks a bubble (reset, flush or redirect)

module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  validD
);

  // ---------------------------------------------------------------------------
  // Fetch-side state
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] pcf;
  logic [DATA_WIDTH-1:0] pc_plus4_f;
  logic [DATA_WIDTH-1:0] redirect_target;

  // Next-state values for every register, resolved combinationally so the
  // sequential block only has to deal with reset.
  logic [DATA_WIDTH-1:0] pcf_nxt;
  logic [DATA_WIDTH-1:0] instr_d_nxt;
  logic [DATA_WIDTH-1:0] pc_d_nxt;
  logic [DATA_WIDTH-1:0] pc_plus4_d_nxt;
  logic                  valid_d_nxt;

  // Plain modulo-2^W add: 0xFFFF_FFFC + 4 wraps to 0 by truncation.
  assign pc_plus4_f = pcf + DATA_WIDTH'(4);

  // Bit 0 is cleared so JALR targets are halfword-aligned; bit 1 passes
  // through untouched because misaligned fetch is not trapped here.
  assign redirect_target = {redirect_pc[DATA_WIDTH-1:1], 1'b0};

  // Memory address is straight from the PC register: no input reaches an
  // output combinationally.
  assign imem_addr = pcf;

  // ---------------------------------------------------------------------------
  // PC next-state: redirect > stall > sequential
  // ---------------------------------------------------------------------------
  always_comb begin
    pcf_nxt = pc_plus4_f;
    if (redirect) begin
      pcf_nxt = redirect_target;
    end else if (stall) begin
      pcf_nxt = pcf;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID next-state: (redirect | flush) > stall > capture
  // ---------------------------------------------------------------------------
  // A redirect squashes whatever sits in fetch even when stall is asserted:
  // the branch in execute is older than the stalled instruction, so that
  // instruction is on the wrong path and must not reach decode.
  // On a bubble, PCD/PCPlus4D keep their old values; only validD/instrD
  // describe the bubble, which avoids needless toggling of the PC fields.
  always_comb begin
    instr_d_nxt    = imem_rdata;
    pc_d_nxt       = pcf;
    pc_plus4_d_nxt = pc_plus4_f;
    valid_d_nxt    = 1'b1;
    if (redirect || flush) begin
      instr_d_nxt    = NOP_INSTR;
      pc_d_nxt       = PCD;
      pc_plus4_d_nxt = PCPlus4D;
      valid_d_nxt    = 1'b0;
    end else if (stall) begin
      instr_d_nxt    = instrD;
      pc_d_nxt       = PCD;
      pc_plus4_d_nxt = PCPlus4D;
      valid_d_nxt    = validD;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers; reset wins over every other request on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcf      <= RESET_PC;
      instrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      validD   <= 1'b0;
    end else begin
      pcf      <= pcf_nxt;
      instrD   <= instr_d_nxt;
      PCD      <= pc_d_nxt;
      PCPlus4D <= pc_plus4_d_nxt;
      validD   <= valid_d_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        validD;

  int n_cmp;
  int n_err;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instrD      (instrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .validD      (validD)
  );

  // Instruction memory model: an injective map so every address holds a
  // distinct word.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1234_5671;
  endfunction

  assign imem_rdata = word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_d(input string tag, input logic [31:0] ins, input logic [31:0] pcd,
                         input logic [31:0] p4d, input logic vld, input logic [31:0] pcf);
    check({tag, ".instrD"},   instrD,          ins);
    check({tag, ".PCD"},      PCD,             pcd);
    check({tag, ".PCPlus4D"}, PCPlus4D,        p4d);
    check({tag, ".validD"},   {31'd0, validD}, {31'd0, vld});
    check({tag, ".PCF"},      imem_addr,       pcf);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    tick();
    check_d("reset", NOP, 32'h0, 32'h0, 1'b0, RST_PC);

    // Free-run from RESET_PC
    rst = 1'b1;
    tick();
    check_d("run0", word(32'hBFC0_0000), 32'hBFC0_0000, 32'hBFC0_0004, 1'b1, 32'hBFC0_0004);
    tick();
    check_d("run1", word(32'hBFC0_0004), 32'hBFC0_0004, 32'hBFC0_0008, 1'b1, 32'hBFC0_0008);
    tick();
    check_d("run2", word(32'hBFC0_0008), 32'hBFC0_0008, 32'hBFC0_000C, 1'b1, 32'hBFC0_000C);

    // Stall 3 cycles holding the word at 0xBFC00008
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_d("stall", word(32'hBFC0_0008), 32'hBFC0_0008, 32'hBFC0_000C, 1'b1, 32'hBFC0_000C);
    end
    stall = 1'b0;
    tick();
    check_d("unstall", word(32'hBFC0_000C), 32'hBFC0_000C, 32'hBFC0_0010, 1'b1, 32'hBFC0_0010);

    // Redirect with bit 0 set
    redirect    = 1'b1;
    redirect_pc = 32'hBFC0_0101;
    tick();
    check_d("redir", NOP, 32'hBFC0_000C, 32'hBFC0_0010, 1'b0, 32'hBFC0_0100);
    redirect = 1'b0;
    tick();
    check_d("redir_tgt", word(32'hBFC0_0100), 32'hBFC0_0100, 32'hBFC0_0104, 1'b1, 32'hBFC0_0104);

    // Redirect + stall: redirect wins; bit 1 of the target passes through
    redirect    = 1'b1;
    stall       = 1'b1;
    redirect_pc = 32'hBFC0_0202;
    tick();
    check_d("redir_stall", NOP, 32'hBFC0_0100, 32'hBFC0_0104, 1'b0, 32'hBFC0_0202);
    redirect = 1'b0;
    stall    = 1'b0;
    tick();
    check_d("redir_stall_tgt", word(32'hBFC0_0202), 32'hBFC0_0202, 32'hBFC0_0206, 1'b1, 32'hBFC0_0206);

    // Flush alone: bubble, PC advances
    flush = 1'b1;
    tick();
    check_d("flush", NOP, 32'hBFC0_0202, 32'hBFC0_0206, 1'b0, 32'hBFC0_020A);
    flush = 1'b0;
    tick();
    check_d("flush_after", word(32'hBFC0_020A), 32'hBFC0_020A, 32'hBFC0_020E, 1'b1, 32'hBFC0_020E);

    // Flush + stall: bubble, PC holds
    flush = 1'b1;
    stall = 1'b1;
    tick();
    check_d("flush_stall", NOP, 32'hBFC0_020A, 32'hBFC0_020E, 1'b0, 32'hBFC0_020E);
    flush = 1'b0;
    stall = 1'b0;
    tick();
    check_d("flush_stall_after", word(32'hBFC0_020E), 32'hBFC0_020E, 32'hBFC0_0212, 1'b1, 32'hBFC0_0212);

    // PC wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    check_d("wrap_redir", NOP, 32'hBFC0_020E, 32'hBFC0_0212, 1'b0, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick();
    check_d("wrap0", word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000);
    tick();
    check_d("wrap1", word(32'h0000_0000), 32'h0000_0000, 32'h0000_0004, 1'b1, 32'h0000_0004);

    // Reset during stall + flush
    stall = 1'b1;
    flush = 1'b1;
    rst   = 1'b0;
    tick();
    check_d("rst_mid", NOP, 32'h0, 32'h0, 1'b0, RST_PC);
    rst   = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    tick();
    check_d("rst_resume", word(32'hBFC0_0000), 32'hBFC0_0000, 32'hBFC0_0004, 1'b1, 32'hBFC0_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined RV32I core. It owns the program counter and drives the instruction-memory address. It latches the fetched word into the decode-stage register that feeds the control unit and the register file. It also applies the hazard unit's stall and flush requests and the execute stage's branch/jump redirects.

## Interface
- DATA_WIDTH, 32, instruction and PC width
- RESET_PC, 32'hBFC0_0000, PC value loaded by reset
- NOP_INSTR, 32'h0000_0013, encoding inserted on flush (addi x0,x0,0)

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- stall  input  1  hazard unit: hold PCF and IF/ID contents
- flush  input  1  hazard unit: replace IF/ID contents with bubble
- redirect  input  1  execute stage: taken branch or jump resolved
- redirect_pc  input  DATA_WIDTH  target PC for redirect (bit 0 ignored, forced 0)
- imem_addr  output  DATA_WIDTH  instruction memory address (= PCF)
- imem_rdata  input  DATA_WIDTH  instruction word, combinational read of imem_addr
- instrD  output  DATA_WIDTH  decode-stage instruction (to control unit / regfile)
- PCD  output  DATA_WIDTH  PC of instrD
- PCPlus4D  output  DATA_WIDTH  PCD + 4 (JAL/JALR link value)
- validD  output  1  instrD is a real fetched instruction, not a bubble

## Operation
- Registers: PCF, plus IF/ID fields instrD, PCD, PCPlus4D, validD.
- imem_addr = PCF continuously. PCPlus4F = PCF + 4, modulo 2^DATA_WIDTH; 32'hFFFF_FFFC wraps to 0.
- PCF next-state priority, highest first:
  - rst low: RESET_PC
  - redirect: {redirect_pc[31:1],1'b0}
  - stall: hold
  - otherwise: PCPlus4F
- IF/ID next-state priority, highest first:
  - rst low: instrD=NOP_INSTR, PCD=0, PCPlus4D=0, validD=0
  - redirect or flush: instrD=NOP_INSTR, validD=0; PCD/PCPlus4D hold
  - stall: hold all fields
  - otherwise: instrD=imem_rdata, PCD=PCF, PCPlus4D=PCPlus4F, validD=1
- Redirect overrides stall for both PCF and IF/ID. The older branch in execute wins, and the stalled wrong-path instruction is squashed.
- Flush without redirect leaves PCF advancing normally unless stall is also high; then PCF holds while IF/ID is bubbled.
- No misalignment trap. redirect_pc[1] is passed through and bit 0 is cleared.
- No internal FSM beyond the registers. The only mode is the reset-bubble/valid tracking via validD.

## Timing
- Reset: with rst low at edge k, PCF=RESET_PC and IF/ID=bubble after edge k. The first real instruction (at RESET_PC) appears in instrD with validD=1 after the first edge with rst high and stall low.
- Fetch-to-decode latency: 1 cycle. The word at PCF in cycle n is in instrD in cycle n+1.
- Redirect asserted in cycle n: after edge n, PCF=target and instrD=NOP, validD=0. The target instruction appears in instrD in cycle n+2.
- Stall: every cycle stall is high and redirect is low, PCF and IF/ID are unchanged. Release resumes with no lost or duplicated instruction.
- Reset mid-operation (rst low during stall, redirect or flush): reset wins on that edge. All pending state is discarded.
- Combinational paths: imem_addr from PCF only. No input-to-output combinational path.

## Test plan
- Reset then free-run, imem[i]=distinct words: after release, instrD sequence matches imem[BFC00000], [BFC00004], ... one per cycle. PCPlus4D = PCD+4 and validD=1 from the first post-reset fetch.
- Stall 3 cycles while instrD=word at 0xBFC00008: instrD, PCD and PCF are unchanged for 3 cycles. The next cycle gives the word at 0xBFC0000C; no skip or duplicate.
- redirect=1, redirect_pc=0xBFC00101 in cycle n: PCF=0xBFC00100 at n+1, instrD=0x00000013 with validD=0 at n+1, and the word at 0xBFC00100 is in instrD at n+2.
- redirect and stall both high in one cycle: PCF takes the target and IF/ID is bubbled, not held. flush alone: bubble inserted and PCF advances by 4.
- PC wrap: redirect to 0xFFFFFFFC, then free-run: PCF=0x00000000 next cycle and PCPlus4D for 0xFFFFFFFC reads 0x00000000.
- rst driven low during an active stall+flush: after that edge, PCF=RESET_PC, instrD=NOP, PCD=0 and validD=0. Normal fetch resumes from RESET_PC after release.
